// File: rtl/imem_port_arbiter_if.sv
// Requester-side bundle for the boot ROM port arbiter: one fetch channel and one
// data channel, each with a request/grant handshake and a valid/ready response.
interface imem_port_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  // Fetch channel
  logic                  f_req_i;
  logic [DATA_WIDTH-1:0] f_addr_i;
  logic                  f_gnt_o;
  logic                  f_rvalid_o;
  logic [DATA_WIDTH-1:0] f_rdata_o;
  logic                  f_err_o;
  logic                  f_rready_i;

  // Data channel; d_size_i: 00 byte, 01 half, 10 word, 11 illegal
  logic                  d_req_i;
  logic [DATA_WIDTH-1:0] d_addr_i;
  logic [1:0]            d_size_i;
  logic                  d_gnt_o;
  logic                  d_rvalid_o;
  logic [DATA_WIDTH-1:0] d_rdata_o;
  logic                  d_err_o;
  logic                  d_rready_i;

  // Arbiter side
  modport slave (
    input  f_req_i, f_addr_i, f_rready_i,
    input  d_req_i, d_addr_i, d_size_i, d_rready_i,
    output f_gnt_o, f_rvalid_o, f_rdata_o, f_err_o,
    output d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o
  );

  // Requester side
  modport master (
    output f_req_i, f_addr_i, f_rready_i,
    output d_req_i, d_addr_i, d_size_i, d_rready_i,
    input  f_gnt_o, f_rvalid_o, f_rdata_o, f_err_o,
    input  d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o
  );

endinterface

// File: rtl/imem_port_arbiter.sv
// Shares the single combinational read port of the boot ROM between the fetch
// stage and the data-side load path. Round-robin per-cycle grant, range and
// alignment checks at grant, registered responses held until accepted.
module imem_port_arbiter #(
  parameter int unsigned           DATA_WIDTH       = 32,
  parameter logic [DATA_WIDTH-1:0] FIRST_INSTR_ADDR = 32'hBFC00000,
  parameter logic [DATA_WIDTH-1:0] LAST_INSTR_ADDR  = 32'hBFC00FFF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  imem_port_arbiter_if.slave    bus,
  output logic [DATA_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_instr_i
);

  typedef enum logic {PortFetch, PortData} port_e;

  // One extra bit so that addr + span cannot wrap past the top of the space
  localparam logic [DATA_WIDTH:0] FirstExt = {1'b0, FIRST_INSTR_ADDR};
  localparam logic [DATA_WIDTH:0] LastExt  = {1'b0, LAST_INSTR_ADDR};

  port_e last_q, last_d;

  logic                  f_rvalid_q, f_err_q;
  logic [DATA_WIDTH-1:0] f_rdata_q;
  logic                  d_rvalid_q, d_err_q;
  logic [DATA_WIDTH-1:0] d_rdata_q;

  logic f_elig, d_elig;
  logic f_gnt, d_gnt;

  logic                  f_bad;
  logic [DATA_WIDTH:0]   f_end;
  logic                  d_bad;
  logic                  d_misalign;
  logic [1:0]            d_span;
  logic [DATA_WIDTH:0]   d_end;
  logic [DATA_WIDTH-1:0] d_data;

  // Eligibility, round-robin grant and ROM address steering
  always_comb begin
    f_elig     = bus.f_req_i & (~f_rvalid_q | bus.f_rready_i);
    d_elig     = bus.d_req_i & (~d_rvalid_q | bus.d_rready_i);
    f_gnt      = ~rst_i & f_elig & (~d_elig | (last_q == PortData));
    d_gnt      = ~rst_i & d_elig & (~f_elig | (last_q == PortFetch));
    last_d     = last_q;
    rom_addr_o = FIRST_INSTR_ADDR;
    if (f_gnt) begin
      last_d     = PortFetch;
      rom_addr_o = {bus.f_addr_i[DATA_WIDTH-1:2], 2'b00};
    end else if (d_gnt) begin
      last_d     = PortData;
      rom_addr_o = {bus.d_addr_i[DATA_WIDTH-1:2], 2'b00};
    end
  end

  // Fetch legality: word aligned and all four bytes inside the ROM window
  always_comb begin
    f_end = {1'b0, bus.f_addr_i} + {{(DATA_WIDTH - 1){1'b0}}, 2'd3};
    f_bad = (bus.f_addr_i[1:0] != 2'b00) ||
            ({1'b0, bus.f_addr_i} < FirstExt) ||
            (f_end > LastExt);
  end

  // Data legality: legal size, natural alignment, every byte inside the window
  always_comb begin
    d_span     = 2'd0;
    d_misalign = 1'b0;
    unique case (bus.d_size_i)
      2'b00: d_span = 2'd0;
      2'b01: begin
        d_span     = 2'd1;
        d_misalign = bus.d_addr_i[0];
      end
      2'b10: begin
        d_span     = 2'd3;
        d_misalign = |bus.d_addr_i[1:0];
      end
      default: d_span = 2'd0;
    endcase
    d_end = {1'b0, bus.d_addr_i} + {{(DATA_WIDTH - 1){1'b0}}, d_span};
    d_bad = (bus.d_size_i == 2'b11) || d_misalign ||
            ({1'b0, bus.d_addr_i} < FirstExt) ||
            (d_end > LastExt);
  end

  // Lane extraction; big-endian word, lowest byte address in the top lane.
  // Lane decoding assumes a 32-bit ROM word.
  always_comb begin
    d_data = '0;
    unique case (bus.d_size_i)
      2'b00: begin
        unique case (bus.d_addr_i[1:0])
          2'd0: d_data[7:0] = rom_instr_i[31:24];
          2'd1: d_data[7:0] = rom_instr_i[23:16];
          2'd2: d_data[7:0] = rom_instr_i[15:8];
          default: d_data[7:0] = rom_instr_i[7:0];
        endcase
      end
      2'b01: begin
        if (bus.d_addr_i[1]) d_data[15:0] = rom_instr_i[15:0];
        else                 d_data[15:0] = rom_instr_i[31:16];
      end
      2'b10: d_data = rom_instr_i;
      default: d_data = '0;
    endcase
  end

  // Last-grant pointer; reset favours fetch on the first tie
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_q <= PortData;
    else       last_q <= last_d;
  end

  // Fetch response slot: load on grant, clear on acceptance
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      f_rvalid_q <= 1'b0;
      f_err_q    <= 1'b0;
      f_rdata_q  <= '0;
    end else if (f_gnt) begin
      f_rvalid_q <= 1'b1;
      f_err_q    <= f_bad;
      f_rdata_q  <= f_bad ? '0 : rom_instr_i;
    end else if (f_rvalid_q && bus.f_rready_i) begin
      f_rvalid_q <= 1'b0;
    end
  end

  // Data response slot: load on grant, clear on acceptance
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      d_rvalid_q <= 1'b0;
      d_err_q    <= 1'b0;
      d_rdata_q  <= '0;
    end else if (d_gnt) begin
      d_rvalid_q <= 1'b1;
      d_err_q    <= d_bad;
      d_rdata_q  <= d_bad ? '0 : d_data;
    end else if (d_rvalid_q && bus.d_rready_i) begin
      d_rvalid_q <= 1'b0;
    end
  end

  assign bus.f_gnt_o    = f_gnt;
  assign bus.f_rvalid_o = f_rvalid_q;
  assign bus.f_rdata_o  = f_rdata_q;
  assign bus.f_err_o    = f_err_q;
  assign bus.d_gnt_o    = d_gnt;
  assign bus.d_rvalid_o = d_rvalid_q;
  assign bus.d_rdata_o  = d_rdata_q;
  assign bus.d_err_o    = d_err_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a small ROM model.
module tb_imem_port_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] rom_addr;
  logic [31:0] rom_instr;

  int checks;
  int failures;

  imem_port_arbiter_if #(.DATA_WIDTH(32)) bus ();

  imem_port_arbiter #(
    .DATA_WIDTH      (32),
    .FIRST_INSTR_ADDR(32'hBFC00000),
    .LAST_INSTR_ADDR (32'hBFC00FFF)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (bus),
    .rom_addr_o (rom_addr),
    .rom_instr_i(rom_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'hBFC00000: rom_word = 32'h12345678;
      32'hBFC00004: rom_word = 32'hCAFEF00D;
      default:      rom_word = {a[15:0], 16'hBEEF};
    endcase
  endfunction

  assign rom_instr = rom_word(rom_addr);

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] exp;
  } dvec_t;

  typedef struct {
    logic        is_fetch;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        exp_err;
    logic [31:0] exp_data;
  } evec_t;

  dvec_t dv[5];
  evec_t ev[9];

  task automatic test_reset();
    rst = 1'b1;
    bus.f_req_i = 1'b1; bus.f_addr_i = 32'hBFC00000; bus.f_rready_i = 1'b1;
    bus.d_req_i = 1'b1; bus.d_addr_i = 32'hBFC00000; bus.d_size_i = 2'b10;
    bus.d_rready_i = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (bus.f_gnt_o !== 1'b0) begin failures++;
      $display("FAIL reset_f_gnt got=%0h exp=0", bus.f_gnt_o); end
    checks++; if (bus.d_gnt_o !== 1'b0) begin failures++;
      $display("FAIL reset_d_gnt got=%0h exp=0", bus.d_gnt_o); end
    checks++; if (bus.f_rvalid_o !== 1'b0 || bus.d_rvalid_o !== 1'b0) begin failures++;
      $display("FAIL reset_rvalid got=%0h/%0h exp=0/0", bus.f_rvalid_o, bus.d_rvalid_o); end
    checks++; if (bus.f_rdata_o !== 32'h0 || bus.d_rdata_o !== 32'h0) begin failures++;
      $display("FAIL reset_rdata got=%0h/%0h exp=0/0", bus.f_rdata_o, bus.d_rdata_o); end
    checks++; if (bus.f_err_o !== 1'b0 || bus.d_err_o !== 1'b0) begin failures++;
      $display("FAIL reset_err got=%0h/%0h exp=0/0", bus.f_err_o, bus.d_err_o); end
    checks++; if (rom_addr !== 32'hBFC00000) begin failures++;
      $display("FAIL reset_rom_addr got=%0h exp=bfc00000", rom_addr); end
    rst = 1'b0;
    bus.f_req_i = 1'b0; bus.d_req_i = 1'b0;
    #1;
    checks++; if (rom_addr !== 32'hBFC00000) begin failures++;
      $display("FAIL idle_rom_addr got=%0h exp=bfc00000", rom_addr); end
  endtask

  task automatic test_fetch_basic();
    @(negedge clk);
    bus.f_req_i = 1'b1; bus.f_addr_i = 32'hBFC00000; bus.f_rready_i = 1'b1;
    #1;
    checks++; if (bus.f_gnt_o !== 1'b1 || bus.d_gnt_o !== 1'b0) begin failures++;
      $display("FAIL fetch_gnt got=%0h/%0h exp=1/0", bus.f_gnt_o, bus.d_gnt_o); end
    checks++; if (rom_addr !== 32'hBFC00000) begin failures++;
      $display("FAIL fetch_rom_addr got=%0h exp=bfc00000", rom_addr); end
    @(posedge clk); #1;
    checks++; if (bus.f_rvalid_o !== 1'b1 || bus.f_rdata_o !== 32'h12345678 ||
                  bus.f_err_o !== 1'b0) begin failures++;
      $display("FAIL fetch_resp got=%0h/%0h/%0h exp=1/12345678/0",
               bus.f_rvalid_o, bus.f_rdata_o, bus.f_err_o); end
    @(negedge clk);
    bus.f_req_i = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.f_rvalid_o !== 1'b0) begin failures++;
      $display("FAIL fetch_accept got=%0h exp=0", bus.f_rvalid_o); end
  endtask

  task automatic test_data_reads();
    dv[0] = '{32'hBFC00001, 2'b00, 32'h00000034};
    dv[1] = '{32'hBFC00002, 2'b01, 32'h00005678};
    dv[2] = '{32'hBFC00000, 2'b10, 32'h12345678};
    dv[3] = '{32'hBFC00007, 2'b00, 32'h0000000D};
    dv[4] = '{32'hBFC00004, 2'b01, 32'h0000CAFE};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.d_req_i = 1'b1; bus.d_addr_i = dv[i].addr; bus.d_size_i = dv[i].size;
      bus.d_rready_i = 1'b1;
      #1;
      checks++; if (bus.d_gnt_o !== 1'b1) begin failures++;
        $display("FAIL data_gnt[%0d] got=%0h exp=1", i, bus.d_gnt_o); end
      checks++; if (rom_addr !== (dv[i].addr & 32'hFFFFFFFC)) begin failures++;
        $display("FAIL data_rom_addr[%0d] got=%0h exp=%0h", i, rom_addr,
                 dv[i].addr & 32'hFFFFFFFC); end
      @(posedge clk); #1;
      checks++; if (bus.d_rvalid_o !== 1'b1 || bus.d_rdata_o !== dv[i].exp ||
                    bus.d_err_o !== 1'b0) begin failures++;
        $display("FAIL data_resp[%0d] got=%0h/%0h/%0h exp=1/%0h/0", i,
                 bus.d_rvalid_o, bus.d_rdata_o, bus.d_err_o, dv[i].exp); end
    end
    @(negedge clk);
    bus.d_req_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic exp_f;
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    bus.f_req_i = 1'b1; bus.f_addr_i = 32'hBFC00004; bus.f_rready_i = 1'b1;
    bus.d_req_i = 1'b1; bus.d_addr_i = 32'hBFC00000; bus.d_size_i = 2'b10;
    bus.d_rready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_f = (i % 2 == 0);
      if (i > 0) @(negedge clk);
      #1;
      checks++; if (bus.f_gnt_o !== exp_f || bus.d_gnt_o !== !exp_f) begin failures++;
        $display("FAIL b2b_gnt[%0d] got=%0h/%0h exp=%0h/%0h", i, bus.f_gnt_o,
                 bus.d_gnt_o, exp_f, !exp_f); end
      @(posedge clk); #1;
      checks++; if (bus.f_rvalid_o !== exp_f || bus.d_rvalid_o !== !exp_f) begin failures++;
        $display("FAIL b2b_rvalid[%0d] got=%0h/%0h exp=%0h/%0h", i, bus.f_rvalid_o,
                 bus.d_rvalid_o, exp_f, !exp_f); end
      if (exp_f) begin
        checks++; if (bus.f_rdata_o !== 32'hCAFEF00D) begin failures++;
          $display("FAIL b2b_f_rdata[%0d] got=%0h exp=cafef00d", i, bus.f_rdata_o); end
      end else begin
        checks++; if (bus.d_rdata_o !== 32'h12345678) begin failures++;
          $display("FAIL b2b_d_rdata[%0d] got=%0h exp=12345678", i, bus.d_rdata_o); end
      end
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    bus.f_req_i = 1'b1; bus.f_addr_i = 32'hBFC00004; bus.f_rready_i = 1'b1;
    bus.d_req_i = 1'b0;
    #1;
    checks++; if (bus.f_gnt_o !== 1'b1) begin failures++;
      $display("FAIL stall_first_gnt got=%0h exp=1", bus.f_gnt_o); end
    @(posedge clk);
    @(negedge clk);
    bus.f_rready_i = 1'b0; bus.f_addr_i = 32'hBFC00000;
    bus.d_req_i = 1'b1; bus.d_addr_i = 32'hBFC00001; bus.d_size_i = 2'b00;
    bus.d_rready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++; if (bus.f_gnt_o !== 1'b0 || bus.d_gnt_o !== 1'b1) begin failures++;
        $display("FAIL stall_gnt[%0d] got=%0h/%0h exp=0/1", i, bus.f_gnt_o, bus.d_gnt_o); end
      @(posedge clk); #1;
      checks++; if (bus.f_rvalid_o !== 1'b1 || bus.f_rdata_o !== 32'hCAFEF00D) begin
        failures++;
        $display("FAIL stall_f_hold[%0d] got=%0h/%0h exp=1/cafef00d", i,
                 bus.f_rvalid_o, bus.f_rdata_o); end
      checks++; if (bus.d_rvalid_o !== 1'b1 || bus.d_rdata_o !== 32'h00000034) begin
        failures++;
        $display("FAIL stall_d_resp[%0d] got=%0h/%0h exp=1/34", i,
                 bus.d_rvalid_o, bus.d_rdata_o); end
    end
    @(negedge clk);
    bus.f_rready_i = 1'b1;
    #1;
    checks++; if (bus.f_gnt_o !== 1'b1 || bus.d_gnt_o !== 1'b0) begin failures++;
      $display("FAIL stall_regrant got=%0h/%0h exp=1/0", bus.f_gnt_o, bus.d_gnt_o); end
    @(posedge clk); #1;
    checks++; if (bus.f_rvalid_o !== 1'b1 || bus.f_rdata_o !== 32'h12345678) begin
      failures++;
      $display("FAIL stall_regrant_resp got=%0h/%0h exp=1/12345678",
               bus.f_rvalid_o, bus.f_rdata_o); end
    @(negedge clk);
    bus.f_req_i = 1'b0; bus.d_req_i = 1'b0;
  endtask

  task automatic test_errors();
    ev[0] = '{1'b1, 32'hBFC00002, 2'b10, 1'b1, 32'h0};
    ev[1] = '{1'b0, 32'hBFC00FFE, 2'b10, 1'b1, 32'h0};
    ev[2] = '{1'b0, 32'h00000000, 2'b00, 1'b1, 32'h0};
    ev[3] = '{1'b0, 32'hBFC00000, 2'b11, 1'b1, 32'h0};
    ev[4] = '{1'b1, 32'hBFC01000, 2'b10, 1'b1, 32'h0};
    ev[5] = '{1'b0, 32'hBFBFFFFF, 2'b00, 1'b1, 32'h0};
    ev[6] = '{1'b0, 32'hBFC00FFF, 2'b00, 1'b0, 32'h000000EF};
    ev[7] = '{1'b1, 32'hBFC00FFC, 2'b10, 1'b0, 32'h0FFCBEEF};
    ev[8] = '{1'b0, 32'hBFC00FFE, 2'b01, 1'b0, 32'h0000BEEF};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.f_rready_i = 1'b1; bus.d_rready_i = 1'b1;
      bus.f_req_i = ev[i].is_fetch;  bus.f_addr_i = ev[i].addr;
      bus.d_req_i = !ev[i].is_fetch; bus.d_addr_i = ev[i].addr;
      bus.d_size_i = ev[i].size;
      #1;
      if (ev[i].is_fetch) begin
        checks++; if (bus.f_gnt_o !== 1'b1) begin failures++;
          $display("FAIL err_f_gnt[%0d] got=%0h exp=1", i, bus.f_gnt_o); end
        @(posedge clk); #1;
        checks++; if (bus.f_rvalid_o !== 1'b1 || bus.f_err_o !== ev[i].exp_err ||
                      bus.f_rdata_o !== ev[i].exp_data) begin failures++;
          $display("FAIL err_f_resp[%0d] got=%0h/%0h/%0h exp=1/%0h/%0h", i,
                   bus.f_rvalid_o, bus.f_err_o, bus.f_rdata_o, ev[i].exp_err,
                   ev[i].exp_data); end
      end else begin
        checks++; if (bus.d_gnt_o !== 1'b1) begin failures++;
          $display("FAIL err_d_gnt[%0d] got=%0h exp=1", i, bus.d_gnt_o); end
        @(posedge clk); #1;
        checks++; if (bus.d_rvalid_o !== 1'b1 || bus.d_err_o !== ev[i].exp_err ||
                      bus.d_rdata_o !== ev[i].exp_data) begin failures++;
          $display("FAIL err_d_resp[%0d] got=%0h/%0h/%0h exp=1/%0h/%0h", i,
                   bus.d_rvalid_o, bus.d_err_o, bus.d_rdata_o, ev[i].exp_err,
                   ev[i].exp_data); end
      end
    end
    @(negedge clk);
    bus.f_req_i = 1'b0; bus.d_req_i = 1'b0;
  endtask

  task automatic test_async_reset();
    // Drain both slots
    @(negedge clk);
    bus.f_req_i = 1'b0; bus.d_req_i = 1'b0;
    bus.f_rready_i = 1'b1; bus.d_rready_i = 1'b1;
    @(negedge clk);
    bus.f_req_i = 1'b1; bus.f_addr_i = 32'hBFC00000;
    @(negedge clk);
    bus.f_req_i = 1'b0; bus.f_rready_i = 1'b0;
    bus.d_req_i = 1'b1; bus.d_addr_i = 32'hBFC00004; bus.d_size_i = 2'b10;
    bus.d_rready_i = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.f_rvalid_o !== 1'b1 || bus.d_rvalid_o !== 1'b1) begin failures++;
      $display("FAIL arst_setup got=%0h/%0h exp=1/1", bus.f_rvalid_o, bus.d_rvalid_o); end
    @(negedge clk);
    bus.f_req_i = 1'b1; bus.d_req_i = 1'b1;
    bus.f_rready_i = 1'b1; bus.d_rready_i = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.f_rvalid_o !== 1'b0 || bus.d_rvalid_o !== 1'b0) begin failures++;
      $display("FAIL arst_rvalid got=%0h/%0h exp=0/0", bus.f_rvalid_o, bus.d_rvalid_o); end
    checks++; if (bus.f_rdata_o !== 32'h0 || bus.d_rdata_o !== 32'h0) begin failures++;
      $display("FAIL arst_rdata got=%0h/%0h exp=0/0", bus.f_rdata_o, bus.d_rdata_o); end
    checks++; if (bus.f_gnt_o !== 1'b0 || bus.d_gnt_o !== 1'b0) begin failures++;
      $display("FAIL arst_gnt got=%0h/%0h exp=0/0", bus.f_gnt_o, bus.d_gnt_o); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.f_gnt_o !== 1'b1 || bus.d_gnt_o !== 1'b0) begin failures++;
      $display("FAIL arst_first_tie got=%0h/%0h exp=1/0", bus.f_gnt_o, bus.d_gnt_o); end
    @(posedge clk); #1;
    checks++; if (bus.f_rvalid_o !== 1'b1 || bus.d_rvalid_o !== 1'b0) begin failures++;
      $display("FAIL arst_after_resp got=%0h/%0h exp=1/0", bus.f_rvalid_o,
               bus.d_rvalid_o); end
    @(negedge clk); #1;
    checks++; if (bus.f_gnt_o !== 1'b0 || bus.d_gnt_o !== 1'b1) begin failures++;
      $display("FAIL arst_second_tie got=%0h/%0h exp=0/1", bus.f_gnt_o, bus.d_gnt_o); end
    bus.f_req_i = 1'b0; bus.d_req_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.f_req_i = 1'b0; bus.f_addr_i = '0; bus.f_rready_i = 1'b0;
    bus.d_req_i = 1'b0; bus.d_addr_i = '0; bus.d_size_i = 2'b00; bus.d_rready_i = 1'b0;
    test_reset();
    test_fetch_basic();
    test_data_reads();
    test_back_to_back();
    test_stall();
    test_errors();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
